// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with operand forwarding, ALU, iterative
// multiply/divide unit and the EX/MEM pipeline register.
module ex_stage_pipe #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      alu_op,
  input  logic [1:0]      fwd1_sel,
  input  logic [1:0]      fwd2_sel,
  input  logic            src1_pc_sel,
  input  logic            src2_imm_sel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] fwd_exmem,
  input  logic [XLEN-1:0] fwd_memwb,
  input  logic [4:0]      rd_addr,
  input  logic            rd_we,
  input  logic            mem_stall,
  input  logic            flush,
  output logic            ex_busy,
  output logic [XLEN-1:0] result_comb,
  output logic            out_valid,
  output logic            out_rd_we,
  output logic [4:0]      out_rd_addr,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  md_state_t       state, state_nx;
  logic [CW-1:0]   md_cnt;
  logic [3:0]      md_op;
  logic [XLEN-1:0] md_a, md_b, md_acc;
  logic [XLEN-1:0] f1, f2, op1, op2, alu_res, md_res;
  logic [XLEN:0]   rem_sh, diff;
  logic [SHW-1:0]  shamt;
  logic            is_md, start, div_borrow;

  assign op1        = src1_pc_sel  ? pc  : f1;
  assign op2        = src2_imm_sel ? imm : f2;
  assign shamt      = op2[SHW-1:0];
  assign is_md      = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign start      = in_valid && is_md && !flush;
  assign ex_busy    = !rst && in_valid && is_md && (state != DONE) && !flush;
  assign rem_sh     = {md_acc, md_a[XLEN-1]};
  assign diff       = rem_sh - {1'b0, md_b};
  assign div_borrow = diff[XLEN];
  assign md_res     = (md_op == OP_DIVU) ? md_a : md_acc;
  assign result_comb = ((state == DONE) && is_md) ? md_res : alu_res;

  // Forwarding muxes: 01 takes the EX/MEM value, 10 the MEM/WB value, else register data
  always_comb begin
    f1 = rs1_data;
    f2 = rs2_data;
    case (fwd1_sel)
      2'b01:   f1 = fwd_exmem;
      2'b10:   f1 = fwd_memwb;
      default: f1 = rs1_data;
    endcase
    case (fwd2_sel)
      2'b01:   f2 = fwd_exmem;
      2'b10:   f2 = fwd_memwb;
      default: f2 = rs2_data;
    endcase
  end

  // Single-cycle ALU; unused codes and the mul/div codes give zero here
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $signed(op1) >>> shamt;
      OP_OR:   alu_res = op1 | op2;
      OP_AND:  alu_res = op1 & op2;
      OP_PASS: alu_res = op2;
      default: alu_res = '0;
    endcase
  end

  // Mul/div state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Mul/div next state: flush always wins, DONE waits for the EX/MEM capture
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = BUSY;
      BUSY: begin
        if (flush)                     state_nx = IDLE;
        else if (md_cnt == CW'(1))     state_nx = DONE;
      end
      DONE:    if (flush || !mem_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Mul/div datapath: shift-add multiply or restoring divide, one bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= '0;
      md_op  <= '0;
      md_a   <= '0;
      md_b   <= '0;
      md_acc <= '0;
    end else if ((state == IDLE) && start) begin
      md_cnt <= CW'(XLEN);
      md_op  <= alu_op;
      md_a   <= op1;
      md_b   <= op2;
      md_acc <= '0;
    end else if ((state == BUSY) && !flush) begin
      md_cnt <= md_cnt - CW'(1);
      if (md_op == OP_MUL) begin
        if (md_b[0]) md_acc <= md_acc + md_a;
        md_a <= md_a << 1;
        md_b <= md_b >> 1;
      end else begin
        md_acc <= div_borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        md_a   <= {md_a[XLEN-2:0], ~div_borrow};
      end
    end
  end

  // EX/MEM register: flush, then stall, then bubble while busy, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_rd_we      <= 1'b0;
      out_rd_addr    <= '0;
      out_result     <= '0;
      out_store_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_rd_we <= 1'b0;
    end else if (mem_stall) begin
      out_valid <= out_valid;
    end else if (ex_busy) begin
      out_valid <= 1'b0;
      out_rd_we <= 1'b0;
    end else begin
      out_valid      <= in_valid;
      out_rd_we      <= rd_we && in_valid;
      out_rd_addr    <= rd_addr;
      out_result     <= result_comb;
      out_store_data <= f2;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: scoreboard bench for ex_stage_pipe at XLEN=32 and XLEN=16.
module tb_ex_stage_pipe;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] store;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_busy, last_bubble;
  logic stall_edge = 1'b0;
  exp_t sb32[$];
  exp_t sb16[$];

  logic        in_valid, src1_pc_sel, src2_imm_sel, rd_we, mem_stall, flush;
  logic [3:0]  alu_op;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [31:0] rs1_data, rs2_data, pc, imm, fwd_exmem, fwd_memwb;
  logic [4:0]  rd_addr;
  logic        ex_busy, out_valid, out_rd_we;
  logic [31:0] result_comb, out_result, out_store_data;
  logic [4:0]  out_rd_addr;

  logic        h_in_valid, h_src2_imm_sel;
  logic [3:0]  h_alu_op;
  logic [15:0] h_rs1, h_rs2, h_imm;
  logic        h_ex_busy, h_out_valid, h_out_rd_we;
  logic [15:0] h_result_comb, h_out_result, h_out_store_data;
  logic [4:0]  h_out_rd_addr;

  always #5 clk = ~clk;

  ex_stage_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .src1_pc_sel(src1_pc_sel),
    .src2_imm_sel(src2_imm_sel), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
    .rd_addr(rd_addr), .rd_we(rd_we), .mem_stall(mem_stall), .flush(flush),
    .ex_busy(ex_busy), .result_comb(result_comb), .out_valid(out_valid),
    .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr), .out_result(out_result),
    .out_store_data(out_store_data)
  );

  ex_stage_pipe #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .alu_op(h_alu_op),
    .fwd1_sel(2'b00), .fwd2_sel(2'b00), .src1_pc_sel(1'b0),
    .src2_imm_sel(h_src2_imm_sel), .rs1_data(h_rs1), .rs2_data(h_rs2),
    .pc(16'h0), .imm(h_imm), .fwd_exmem(16'h0), .fwd_memwb(16'h0),
    .rd_addr(5'd1), .rd_we(1'b1), .mem_stall(1'b0), .flush(1'b0),
    .ex_busy(h_ex_busy), .result_comb(h_result_comb), .out_valid(h_out_valid),
    .out_rd_we(h_out_rd_we), .out_rd_addr(h_out_rd_addr), .out_result(h_out_result),
    .out_store_data(h_out_store_data)
  );

  // Cycle count and the stall level seen at each active edge
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    stall_edge <= mem_stall;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance: each fresh capture pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && !stall_edge) begin
      if (sb32.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb32_unexpected: got result 0x%0h expected no output", out_result);
      end else begin
        e = sb32.pop_front();
        checkOutput({e.name, "_result"}, out_result, e.result);
        checkOutput({e.name, "_rd"}, 32'(out_rd_addr), 32'(e.rd));
        checkOutput({e.name, "_we"}, 32'(out_rd_we), 32'(e.we));
        checkOutput({e.name, "_store"}, out_store_data, e.store);
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && h_out_valid) begin
      if (sb16.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb16_unexpected: got result 0x%0h expected no output", h_out_result);
      end else begin
        e = sb16.pop_front();
        checkOutput({e.name, "_result"}, {16'h0, h_out_result}, e.result);
        checkOutput({e.name, "_we"}, 32'(h_out_rd_we), 32'(e.we));
        checkOutput({e.name, "_store"}, {16'h0, h_out_store_data}, e.store);
        checkOutput({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  // Present one op to the 32-bit instance and hold it while ex_busy is high
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                               input logic [31:0] exp_store, input int exp_lat);
    bit done = 0;
    alu_op = op; rs1_data = a; rs2_data = b; rd_addr = rd; in_valid = 1'b1;
    sb32.push_back('{exp_res, rd, rd_we, exp_store, cyc, exp_lat, name});
    last_busy = 0; last_bubble = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (ex_busy) begin
        last_busy++;
        if (k > 0 && out_valid) last_bubble++;
        @(posedge clk); #1;
      end else done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout: ex_busy still 1 expected 0 within 200 cycles", name);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Same for the 16-bit instance
  task automatic applyStimulus16(input string name, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic isel, input logic [15:0] im,
                                 input logic [31:0] exp_res, input logic [31:0] exp_store, input int exp_lat);
    bit done = 0;
    h_alu_op = op; h_rs1 = a; h_rs2 = b; h_src2_imm_sel = isel; h_imm = im; h_in_valid = 1'b1;
    sb16.push_back('{exp_res, 5'd1, 1'b1, exp_store, cyc, exp_lat, name});
    last_busy = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (h_ex_busy) begin
        last_busy++;
        @(posedge clk); #1;
      end else done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout: ex_busy still 1 expected 0 within 200 cycles", name);
    end
    @(posedge clk); #1;
    h_in_valid = 1'b0;
  endtask

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    bit done;
    rst = 1'b1;
    in_valid = 1'b1; alu_op = 4'd11; fwd1_sel = 2'b00; fwd2_sel = 2'b00;
    src1_pc_sel = 1'b0; src2_imm_sel = 1'b0; rs1_data = 32'd3; rs2_data = 32'd4;
    pc = '0; imm = '0; fwd_exmem = '0; fwd_memwb = '0; rd_addr = '0; rd_we = 1'b1;
    mem_stall = 1'b0; flush = 1'b0;
    h_in_valid = 1'b0; h_alu_op = '0; h_rs1 = '0; h_rs2 = '0; h_imm = '0; h_src2_imm_sel = 1'b0;
    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_out_result", out_result, 32'h0);
    checkOutput("reset_ex_busy", 32'(ex_busy), 32'h0);
    checkOutput("reset16_out_valid", 32'(h_out_valid), 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("add", 4'd0, 32'd5, 32'd7, 5'd3, 32'd12, 32'd7, 1);
    fwd1_sel = 2'b01; fwd_exmem = 32'hFFFF_FFFF; fwd2_sel = 2'b10; fwd_memwb = 32'd1;
    applyStimulus("sub_fwd", 4'd1, 32'hAA, 32'hBB, 5'd4, 32'hFFFF_FFFE, 32'd1, 1);
    fwd1_sel = 2'b00; fwd2_sel = 2'b00;
    src2_imm_sel = 1'b1; imm = 32'd31;
    applyStimulus("sra_imm", 4'd7, 32'h8000_0000, 32'h1234, 5'd5, 32'hFFFF_FFFF, 32'h1234, 1);
    src2_imm_sel = 1'b0;
    applyStimulus("sll_wrap", 4'd2, 32'd1, 32'h24, 5'd6, 32'd16, 32'h24, 1);
    applyStimulus("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd1, 32'd1, 1);
    rd_we = 1'b0;
    applyStimulus("sltu_nowe", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'd0, 32'd1, 1);
    rd_we = 1'b1;
    fwd1_sel = 2'b11; fwd2_sel = 2'b11;
    applyStimulus("xor_sel11", 4'd5, 32'hF0F0, 32'hFF00, 5'd9, 32'h0FF0, 32'hFF00, 1);
    fwd1_sel = 2'b00; fwd2_sel = 2'b00;
    applyStimulus("srl", 4'd6, 32'h8000_0000, 32'd31, 5'd10, 32'd1, 32'd31, 1);
    applyStimulus("or", 4'd8, 32'hF0, 32'h0F, 5'd11, 32'hFF, 32'h0F, 1);
    applyStimulus("and", 4'd9, 32'hF0, 32'h3C, 5'd12, 32'h30, 32'h3C, 1);
    src1_pc_sel = 1'b1; pc = 32'h1000; src2_imm_sel = 1'b1; imm = 32'h20;
    applyStimulus("add_pc_imm", 4'd0, 32'h7, 32'h55, 5'd13, 32'h1020, 32'h55, 1);
    applyStimulus("pass_imm", 4'd10, 32'h7, 32'h55, 5'd14, 32'h20, 32'h55, 1);
    src1_pc_sel = 1'b0; src2_imm_sel = 1'b0;
    applyStimulus("op15", 4'd15, 32'd3, 32'd4, 5'd15, 32'd0, 32'd4, 1);
    applyStimulus("op14", 4'd14, 32'd3, 32'd4, 5'd16, 32'd0, 32'd4, 1);

    applyStimulus("mul", 4'd11, 32'h0001_0003, 32'h5, 5'd17, 32'h0005_000F, 32'h5, 34);
    checkOutput("mul_busy_cycles", 32'(last_busy), 32'd33);
    checkOutput("mul_bubbles", 32'(last_bubble), 32'd0);
    applyStimulus("divu", 4'd12, 32'd100, 32'd7, 5'd18, 32'd14, 32'd7, 34);
    applyStimulus("remu", 4'd13, 32'd100, 32'd7, 5'd19, 32'd2, 32'd7, 34);
    applyStimulus("divu_zero", 4'd12, 32'h1234_5678, 32'd0, 5'd20, 32'hFFFF_FFFF, 32'd0, 34);
    checkOutput("divu_zero_busy", 32'(last_busy), 32'd33);
    applyStimulus("remu_zero", 4'd13, 32'd9, 32'd0, 5'd21, 32'd9, 32'd0, 34);

    // Three stall cycles while the multiplier sits in DONE
    alu_op = 4'd11; rs1_data = 32'd6; rs2_data = 32'd7; rd_addr = 5'd22; in_valid = 1'b1;
    sb32.push_back('{32'd42, 5'd22, 1'b1, 32'd7, cyc, 37, "mul_stall"});
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!ex_busy) done = 1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("mul_stall_reached_done", 32'(done), 32'd1);
    mem_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("stall_ex_busy", 32'(ex_busy), 32'h0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'h0);
      checkOutput("stall_out_result", out_result, 32'd9);
      checkOutput("stall_result_comb", result_comb, 32'd42);
    end
    mem_stall = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Flush together with stall drops a valid output
    applyStimulus("add_pre_flush", 4'd0, 32'd1, 32'd1, 5'd23, 32'd2, 32'd1, 1);
    flush = 1'b1; mem_stall = 1'b1; in_valid = 1'b1; alu_op = 4'd0;
    @(posedge clk); #1;
    flush = 1'b0; mem_stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_stall_valid", 32'(out_valid), 32'h0);
    checkOutput("flush_stall_we", 32'(out_rd_we), 32'h0);

    // Flush in the middle of a multiply
    @(posedge clk); #1;
    alu_op = 4'd11; rs1_data = 32'd3; rs2_data = 32'd3; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("busy_before_flush", 32'(ex_busy), 32'h1);
    flush = 1'b1;
    #1;
    checkOutput("flush_busy_drop", 32'(ex_busy), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    applyStimulus("mul_after_flush", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd24, 32'd1, 32'hFFFF_FFFF, 34);
    checkOutput("mul_after_flush_busy", 32'(last_busy), 32'd33);

    // Asynchronous reset in the middle of a multiply
    applyStimulus("add_pre_rst", 4'd0, 32'h11, 32'h22, 5'd25, 32'h33, 32'h22, 1);
    alu_op = 4'd11; rs1_data = 32'd5; rs2_data = 32'd5; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("pre_rst_out_result", out_result, 32'h33);
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_result", out_result, 32'h0);
    checkOutput("rst_out_store", out_store_data, 32'h0);
    checkOutput("rst_out_rd_addr", 32'(out_rd_addr), 32'h0);
    checkOutput("rst_ex_busy", 32'(ex_busy), 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus("add_post_rst", 4'd0, 32'd2, 32'd3, 5'd26, 32'd5, 32'd3, 1);
    applyStimulus("mul_post_rst", 4'd11, 32'd6, 32'd7, 5'd27, 32'd42, 32'd7, 34);

    // XLEN=16 instance
    applyStimulus16("add16", 4'd0, 16'd5, 16'd7, 1'b0, 16'd0, 32'd12, 32'd7, 1);
    applyStimulus16("sra16", 4'd7, 16'h8000, 16'h0, 1'b1, 16'd15, 32'hFFFF, 32'h0, 1);
    applyStimulus16("mul16", 4'd11, 16'h0103, 16'h5, 1'b0, 16'd0, 32'h050F, 32'h5, 18);
    checkOutput("mul16_busy_cycles", 32'(last_busy), 32'd17);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb32_drained", 32'(sb32.size()), 32'd0);
    checkOutput("sb16_drained", 32'(sb16.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute stage with EX/MEM pipeline register for the RISC-V core. It replaces the fixed 32-bit execute block and adds four things: full forwarding-mux selection, PC/immediate operand selection, an iterative multiply/divide unit with a stall handshake, and stall/flush control of the EX/MEM register. It sits between the ID/EX register and the MEM stage. It receives forwarding selects from the hazard unit and drives `ex_busy` back to it.

## Interface
- `XLEN`, default 32: datapath width, must be a power of two ≥ 8.
- `SHW`, default $clog2(XLEN): shift-amount width, derived, not overridden.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: ID/EX holds a valid instruction.
- `alu_op` in 4: operation code, see Operation.
- `fwd1_sel`, `fwd2_sel` in 2 each: 00 register data, 01 `fwd_exmem`, 10 `fwd_memwb`, 11 register data.
- `src1_pc_sel` in 1: 1 selects `pc` as operand 1.
- `src2_imm_sel` in 1: 1 selects `imm` as operand 2.
- `rs1_data`, `rs2_data`, `pc`, `imm`, `fwd_exmem`, `fwd_memwb` in XLEN each.
- `rd_addr` in 5, `rd_we` in 1: destination passed down the pipe.
- `mem_stall` in 1: hold the EX/MEM register.
- `flush` in 1: squash the current EX instruction.
- `ex_busy` out 1: the multi-cycle op is not finished, so the upstream stages must hold.
- `result_comb` out XLEN: combinational result of the current op.
- `out_valid`, `out_rd_we` out 1 each; `out_rd_addr` out 5; `out_result`, `out_store_data` out XLEN: registered EX/MEM outputs.

## Operation
**Operand selection**
- Forwarded operands: `f1` = fwd1_sel(rs1 path); `f2` = fwd2_sel(rs2 path).
- ALU operands:
  - `op1` = `src1_pc_sel` ? `pc` : `f1`.
  - `op2` = `src2_imm_sel` ? `imm` : `f2`.
- `out_store_data` always captures `f2`.

**Single-cycle ops** (`alu_op`)
- 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS (`op2`).
- All arithmetic is modulo 2^XLEN.
- Shifts use `op2[SHW-1:0]`.
- SLT and SLTU yield 0 or 1, zero-extended.
- Codes 14 and 15 yield 0 and are single-cycle.

**Multi-cycle ops**
- 11 MUL: low XLEN bits of the unsigned product; shift-add, one bit per cycle.
- 12 DIVU: unsigned quotient; restoring division, one bit per cycle.
- 13 REMU: unsigned remainder; same division.
- Divide by zero: DIVU gives all ones, REMU gives `op1`. The ops still take full latency.

**Multiply/divide FSM**
- States: IDLE, BUSY, DONE; iteration counter is $clog2(XLEN)+1 bits.
- IDLE → BUSY when `in_valid` & multi-cycle op & !`flush`. Operands are latched and the counter is loaded with XLEN.
- BUSY: one iteration per cycle; the counter decrements. BUSY → DONE on the cycle the counter goes from 1 to 0.
- DONE → IDLE when the EX/MEM register captures (i.e. !`mem_stall`). DONE is held while `mem_stall` is high.
- `flush` in any state → IDLE, and the partial result is discarded.
- BUSY iterations continue while `mem_stall` is high.
- `ex_busy` = `in_valid` & multi-cycle op & (state != DONE) & !`flush`. It is combinational.
- `result_comb` = FSM result in DONE for multi-cycle ops; otherwise the ALU result.

**EX/MEM register update** (priority order)
1. `flush`: `out_valid` and `out_rd_we` ← 0; other fields don't-care (hold).
2. `mem_stall`: all outputs hold.
3. `ex_busy`: insert a bubble (`out_valid` and `out_rd_we` ← 0).
4. Otherwise capture: `out_valid` ← `in_valid`, `out_rd_we` ← `rd_we` & `in_valid`, plus `out_rd_addr`, `out_result` ← `result_comb`, and `out_store_data`.

## Timing
- Reset (asynchronous): all registered outputs go to 0, FSM goes to IDLE, counter goes to 0.
- `ex_busy` is 0 during reset and while idle with no multi-cycle op.
- Single-cycle op: the result appears on `out_*` one cycle after it is presented.
- Multi-cycle op presented in cycle 0, with no stall:
  - `ex_busy` is high in cycles 0..XLEN (XLEN+1 cycles).
  - DONE is reached in cycle XLEN+1.
  - `out_valid` is high with the result in cycle XLEN+2.
- Each cycle of `mem_stall` in DONE adds one cycle of latency.
- Back-to-back multi-cycle ops: the second op enters BUSY in the cycle after the first op's capture. There is no idle gap beyond the IDLE cycle.
- `rst` asserted mid-BUSY aborts immediately. There is no output glitch on `out_valid`.

## Test plan
- Reset, then ADD with `rs1_data`=5, `rs2_data`=7, `fwd*`=00 → `out_result`=12, `out_valid`=1, one cycle later.
- Forwarding: `fwd1_sel`=01, `fwd_exmem`=0xFFFF_FFFF, `fwd2_sel`=10, `fwd_memwb`=1, SUB → `out_result`=0xFFFF_FFFE. Also SRA of 0x8000_0000 by `imm`=31 (`src2_imm_sel`=1) → 0xFFFF_FFFF.
- MUL 0x0001_0003 × 0x0000_0005:
  - `ex_busy` is high for 33 cycles.
  - `out_result`=0x0005_000F appears 34 cycles after issue.
  - Bubbles (`out_valid`=0) are output during the busy window.
- DIVU 100/7 → 14, and REMU 100/7 → 2. DIVU x/0 → 0xFFFF_FFFF, and REMU 9/0 → 9, each with full latency.
- Stall and flush:
  - `mem_stall` held for 3 cycles in DONE keeps the FSM in DONE and the outputs unchanged; the result is captured on release.
  - `flush` mid-BUSY returns the FSM to IDLE, drops `ex_busy` the same cycle, and makes `out_valid`=0.
  - `flush` together with `mem_stall` → `out_valid`=0.
- Asynchronous `rst` pulse mid-BUSY → all outputs are 0 immediately and the FSM is IDLE. A subsequent single-cycle op completes normally.
- Repeat the ADD, SRA and MUL checks with `XLEN`=16. MUL latency becomes 18 cycles.
